// File: rtl/rot_seq.sv
// Multi-cycle 32-bit rotator: one 1-bit rotate step per clock between two valid/ready handshakes.
// Define ROT_SHORTPATH_EN to rotate the short way round (at most WIDTH/2 steps).
module rot_seq #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    amt,
    input  logic             dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE, out_valid only in DONE, so accept and hand-off never coincide.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [AW-1:0]    load_rem;
    logic             load_dir;

`ifdef ROT_SHORTPATH_EN
    localparam logic [AW:0] HALF = (AW+1)'(WIDTH / 2);
    localparam logic [AW:0] FULL = (AW+1)'(WIDTH);

    // Rotating more than half-way one direction equals rotating WIDTH-amt the other way.
    always_comb begin
        load_rem = amt;
        load_dir = dir;
        if ({1'b0, amt} > HALF) begin
            load_rem = AW'(FULL - {1'b0, amt});
            load_dir = ~dir;
        end
    end
`else
    assign load_rem = amt;
    assign load_dir = dir;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    rem_d   = load_rem;
                    dir_d   = load_dir;
                    state_d = (load_rem != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d = dir_q ? {data_q[0], data_q[WIDTH-1:1]}
                               : {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                rem_d  = rem_q - AW'(1);
                if (rem_q == AW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign data_out  = data_q;

endmodule

// File: tb/tb_rot_seq.sv
// Self-checking bench for rot_seq: directed cases, boundaries, back-to-back and randomized requests
// checked against an arithmetic rotate model.
module tb_rot_seq;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    amt;
    logic             dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             busy;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    logic [WIDTH-1:0] exp_q[$];

    rot_seq #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .amt      (amt),
        .dir      (dir),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .busy     (busy)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference model: rotate as plain arithmetic on a doubled word.
    function automatic logic [31:0] model_rot(input logic [31:0] x, input int n, input logic right);
        logic [63:0] dbl;
        int s;
        dbl = {x, x};
        s   = right ? n : (32 - n) % 32;
        dbl = dbl >> s;
        return dbl[31:0];
    endfunction

    function automatic int model_steps(input int n);
`ifdef ROT_SHORTPATH_EN
        return (n > 16) ? 32 - n : n;
`else
        return n;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Driver: one request, optional DONE stall, then hand-off. Sampling is on the falling edge.
    task automatic run_req(input logic [31:0] d, input int a, input logic r, input int stall,
                           input logic [31:0] exp_val, input string name);
        int k;
        int lat;
        bit ir_bad;
        bit stall_bad;
        logic [31:0] held;
        logic [31:0] exp_d;
        k = model_steps(a);
        @(negedge clk);
        out_ready = 1'b0;
        data_in   = d;
        amt       = 5'(a);
        dir       = r;
        in_valid  = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL %s_accept: in_ready=%0b after 50 cycles, required 1", name, in_ready);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp_val);
        @(negedge clk);
        // Scramble inputs after the accept edge; they must have no effect.
        in_valid = 1'b0;
        data_in  = $urandom;
        amt      = 5'($urandom_range(0, 31));
        dir      = 1'($urandom_range(0, 1));
        lat      = 0;
        ir_bad   = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ir_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        // out_valid visible after accept edge + lat is first sampled by edge lat+1.
        checks++;
        if (!out_valid || lat + 1 != k + 1) begin
            errors++;
            $display("FAIL %s_latency: out_valid=%0b sample_edge=%0d, required 1 at edge %0d",
                     name, out_valid, lat + 1, k + 1);
        end
        if (!out_valid) begin
            void'(exp_q.pop_front());
            do_reset();
            return;
        end
        held      = data_out;
        stall_bad = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            if (!out_valid || data_out !== held || in_ready) stall_bad = 1'b1;
        end
        if (in_ready) ir_bad = 1'b1;
        checks++;
        if (ir_bad) begin
            errors++;
            $display("FAIL %s_in_ready: in_ready=1 while busy, required 0", name);
        end
        if (stall > 0) begin
            checks++;
            if (stall_bad) begin
                errors++;
                $display("FAIL %s_stall: data_out=%h out_valid=%0b, required %h held with out_valid=1",
                         name, data_out, out_valid, held);
            end
        end
        exp_d = exp_q.pop_front();
        checks++;
        if (data_out !== exp_d) begin
            errors++;
            $display("FAIL %s_data: data_out=%h, required %h", name, data_out, exp_d);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_handoff: out_valid=%0b in_ready=%0b, required 0 and 1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        checks++;
        if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h, required 0", data_out); end
    endtask

    task automatic test_directed();
        run_req(32'h0000_0001, 1, 1'b1, 0, 32'h8000_0000, "right1");
        run_req(32'h8000_0001, 4, 1'b0, 3, 32'h0000_0018, "left4_stall");
        run_req(32'hDEAD_BEEF, 0, 1'b0, 0, 32'hDEAD_BEEF, "zero_amt");
        run_req(32'h1234_5678, 31, 1'b1, 0, 32'h2468_ACF0, "long31");
    endtask

    task automatic test_boundaries();
        int amts[6] = '{15, 16, 17, 31, 1, 30};
        logic [31:0] d;
        logic r;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            r = 1'(i % 2);
            run_req(d, amts[i], r, 1, model_rot(d, amts[i], r), "boundary");
        end
    endtask

    task automatic test_back_to_back();
        int amts[4] = '{0, 3, 1, 5};
        int unsigned acc[4];
        logic [31:0] d;
        logic [31:0] e;
        logic r;
        int n;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!in_ready) begin errors++; $display("FAIL b2b_ready: in_ready=0 at request %0d, required 1", i); end
            d        = $urandom;
            r        = 1'($urandom_range(0, 1));
            data_in  = d;
            amt      = 5'(amts[i]);
            dir      = r;
            in_valid = 1'b1;
            exp_q.push_back(model_rot(d, amts[i], r));
            acc[i] = cyc;
            @(negedge clk);
            n = 0;
            while (!out_valid && n < 40) begin @(negedge clk); n++; end
            e = exp_q.pop_front();
            checks++;
            if (!out_valid || data_out !== e) begin
                errors++;
                $display("FAIL b2b_data: out_valid=%0b data_out=%h, required 1 and %h", out_valid, data_out, e);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 32'(model_steps(amts[i-1]) + 2)) begin
                errors++;
                $display("FAIL b2b_interval: got %0d cycles, required %0d",
                         acc[i] - acc[i-1], model_steps(amts[i-1]) + 2);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        bit ov;
        ov = 1'b0;
        @(negedge clk);
        data_in   = $urandom;
        amt       = 5'd20;
        dir       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        checks++;
        if (!in_ready) begin errors++; $display("FAIL midrst_ready: in_ready=0, required 1"); end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin
            if (out_valid) ov = 1'b1;
            @(negedge clk);
        end
        if (out_valid) ov = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (out_valid) ov = 1'b1;
        checks++;
        if (ov) begin errors++; $display("FAIL midrst_out_valid: out_valid rose for discarded request, required 0"); end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || data_out !== 32'h0) begin
            errors++;
            $display("FAIL midrst_state: in_ready=%0b busy=%0b data_out=%h, required 1 0 00000000",
                     in_ready, busy, data_out);
        end
        out_ready = 1'b0;
        run_req(32'hFF00_0000, 8, 1'b1, 0, 32'h00FF_0000, "post_reset");
    endtask

    task automatic test_random();
        logic [31:0] d;
        int a;
        logic r;
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            a = $urandom_range(0, 31);
            r = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_req(d, a, r, $urandom_range(0, 3), model_rot(d, a, r), "random");
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        amt       = '0;
        dir       = 1'b0;
        test_reset();
        test_directed();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
